// File: rtl/branch_history_table.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// branch_history_table
//
// Direct-mapped branch predictor for the fetch stage: a table of saturating
// direction counters plus a tagged branch target buffer (BTB). Fetch gets a
// combinational prediction for lookup_pc. Execute trains the tables one cycle
// at a time with resolved outcomes. A saturating mispredict counter is kept
// for performance measurement.
//
// Optional feature: define BHT_GSHARE_EN to build a global history register
// (GHR). The GHR is XORed into the counter index and speculatively shifted on
// BTB hits. Without the macro the counter index is the PC low bits only.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   lookup_valid          fetch request (only gates history speculation)
//   lookup_pc             PC being fetched
//   btb_hit               BTB entry valid with matching tag
//   predicted_taken       btb_hit and counter MSB set
//   predicted_target      BTB target if predicted taken, else lookup_pc + 1
//   predict_hist          history used for this lookup (0 without gshare)
//   update_valid          resolved branch report
//   update_pc             PC of resolved branch
//   update_taken          resolved direction
//   update_target         resolved taken target
//   update_mispredict     earlier prediction was wrong
//   update_hist           predict_hist captured when this branch was looked up
//   perf_mispredicts      saturating mispredict count
// -----------------------------------------------------------------------------
module branch_history_table #(
    parameter int PC_WIDTH   = 16,
    parameter int INDEX_BITS = 4,
    parameter int CTR_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  lookup_valid,
    input  logic [PC_WIDTH-1:0]   lookup_pc,
    output logic                  btb_hit,
    output logic                  predicted_taken,
    output logic [PC_WIDTH-1:0]   predicted_target,
    output logic [INDEX_BITS-1:0] predict_hist,
    input  logic                  update_valid,
    input  logic [PC_WIDTH-1:0]   update_pc,
    input  logic                  update_taken,
    input  logic [PC_WIDTH-1:0]   update_target,
    input  logic                  update_mispredict,
    input  logic [INDEX_BITS-1:0] update_hist,
    output logic [15:0]           perf_mispredicts
);

    localparam int DEPTH    = 1 << INDEX_BITS;
    localparam int TAG_BITS = PC_WIDTH - INDEX_BITS;

    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_ZERO = '0;
    localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1);
    localparam logic [PC_WIDTH-1:0] PC_ONE   = PC_WIDTH'(1);

    // Table state
    logic [CTR_BITS-1:0] ctr_q        [DEPTH];
    logic [DEPTH-1:0]    btb_valid_q;
    logic [TAG_BITS-1:0] btb_tag_q    [DEPTH];
    logic [PC_WIDTH-1:0] btb_target_q [DEPTH];

    // Index / tag decode
    logic [INDEX_BITS-1:0] lookup_idx;
    logic [INDEX_BITS-1:0] lookup_ctr_idx;
    logic [TAG_BITS-1:0]   lookup_tag;
    logic [INDEX_BITS-1:0] update_idx;
    logic [INDEX_BITS-1:0] update_ctr_idx;
    logic [TAG_BITS-1:0]   update_tag;
    logic [CTR_BITS-1:0]   update_ctr;

    assign lookup_idx = lookup_pc[INDEX_BITS-1:0];
    assign lookup_tag = lookup_pc[PC_WIDTH-1:INDEX_BITS];
    assign update_idx = update_pc[INDEX_BITS-1:0];
    assign update_tag = update_pc[PC_WIDTH-1:INDEX_BITS];

`ifdef BHT_GSHARE_EN
    logic [INDEX_BITS-1:0] ghr_q;

    // A mispredict repair restores the history the branch saw and appends
    // its real outcome; this overrides any speculative shift in that cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ghr_q <= '0;
        end else if (update_valid && update_mispredict) begin
            ghr_q <= {update_hist[INDEX_BITS-2:0], update_taken};
        end else if (lookup_valid && btb_hit) begin
            ghr_q <= {ghr_q[INDEX_BITS-2:0], predicted_taken};
        end
    end

    assign lookup_ctr_idx = lookup_idx ^ ghr_q;
    assign update_ctr_idx = update_idx ^ update_hist;
    assign predict_hist   = ghr_q;
`else
    assign lookup_ctr_idx = lookup_idx;
    assign update_ctr_idx = update_idx;
    assign predict_hist   = '0;

    // History inputs have no consumer without the GHR.
    logic unused_hist;
    assign unused_hist = ^{update_hist, lookup_valid};
`endif

    // Lookup: purely combinational, reads pre-update state (no bypass).
    assign btb_hit          = btb_valid_q[lookup_idx] && (btb_tag_q[lookup_idx] == lookup_tag);
    assign predicted_taken  = btb_hit && ctr_q[lookup_ctr_idx][CTR_BITS-1];
    assign predicted_target = predicted_taken ? btb_target_q[lookup_idx] : lookup_pc + PC_ONE;

    assign update_ctr = ctr_q[update_ctr_idx];

    // Direction counters reset to strongly taken and saturate at both ends.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, independent of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= CTR_MAX;
            end
        end else if (update_valid) begin
            if (update_taken) begin
                if (update_ctr != CTR_MAX) begin
                    ctr_q[update_ctr_idx] <= update_ctr + CTR_ONE;
                end
            end else if (update_ctr != CTR_ZERO) begin
                ctr_q[update_ctr_idx] <= update_ctr - CTR_ONE;
            end
        end
    end

    // BTB valid bits are reset so no stale entry can hit after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btb_valid_q <= '0;
        end else if (update_valid && update_taken) begin
            btb_valid_q[update_idx] <= 1'b1;
        end
    end

    // NOTE: tag and target arrays are plain memory without reset; the valid
    // bit alone decides whether their contents are ever used.
    always_ff @(posedge clk) begin
        if (update_valid && update_taken) begin
            btb_tag_q[update_idx]    <= update_tag;
            btb_target_q[update_idx] <= update_target;
        end
    end

    // Mispredict counter holds at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_mispredicts <= '0;
        end else if (update_valid && update_mispredict && (perf_mispredicts != 16'hFFFF)) begin
            perf_mispredicts <= perf_mispredicts + 16'd1;
        end
    end

endmodule

// File: tb/tb_branch_history_table.sv
`timescale 1ns/1ps
module tb_branch_history_table;

    localparam int PW    = 16;
    localparam int IB    = 4;
    localparam int CB    = 2;
    localparam int DEPTH = 1 << IB;
    localparam int CMAX  = (1 << CB) - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          lookup_valid;
    logic [PW-1:0] lookup_pc;
    logic          btb_hit;
    logic          predicted_taken;
    logic [PW-1:0] predicted_target;
    logic [IB-1:0] predict_hist;
    logic          update_valid;
    logic [PW-1:0] update_pc;
    logic          update_taken;
    logic [PW-1:0] update_target;
    logic          update_mispredict;
    logic [IB-1:0] update_hist;
    logic [15:0]   perf_mispredicts;

    always #5 clk = ~clk;

    branch_history_table #(.PC_WIDTH(PW), .INDEX_BITS(IB), .CTR_BITS(CB)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .lookup_valid      (lookup_valid),
        .lookup_pc         (lookup_pc),
        .btb_hit           (btb_hit),
        .predicted_taken   (predicted_taken),
        .predicted_target  (predicted_target),
        .predict_hist      (predict_hist),
        .update_valid      (update_valid),
        .update_pc         (update_pc),
        .update_taken      (update_taken),
        .update_target     (update_target),
        .update_mispredict (update_mispredict),
        .update_hist       (update_hist),
        .perf_mispredicts  (perf_mispredicts)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural reference model: plain integers, saturating arithmetic.
    int m_ctr    [DEPTH];
    bit m_valid  [DEPTH];
    int m_tag    [DEPTH];
    int m_target [DEPTH];
    int m_perf;
    int m_ghr;
    bit gshare;

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_ctr[i]   = CMAX;
            m_valid[i] = 1'b0;
        end
        m_perf = 0;
        m_ghr  = 0;
    endfunction

    function automatic void model_predict(input int pc, output bit hit, output bit taken,
                                          output logic [PW-1:0] target, output logic [IB-1:0] hist);
        int idx;
        int cidx;
        idx    = pc % DEPTH;
        cidx   = gshare ? (idx ^ m_ghr) : idx;
        hit    = m_valid[idx] && (m_tag[idx] == pc / DEPTH);
        taken  = hit && (m_ctr[cidx] >= (CMAX + 1) / 2);
        target = taken ? PW'(m_target[idx]) : PW'((pc + 1) % (1 << PW));
        hist   = gshare ? IB'(m_ghr) : '0;
    endfunction

    task automatic drive(input bit lv, input logic [PW-1:0] lpc, input bit uv, input logic [PW-1:0] upc,
                         input bit ut, input logic [PW-1:0] utgt, input bit um, input logic [IB-1:0] uh);
        lookup_valid      = lv;
        lookup_pc         = lpc;
        update_valid      = uv;
        update_pc         = upc;
        update_taken      = ut;
        update_target     = utgt;
        update_mispredict = um;
        update_hist       = uh;
    endtask

    // Advance one clock and train the model with the inputs currently driven.
    task automatic tick();
        bit            hit;
        bit            taken;
        logic [PW-1:0] tgt;
        logic [IB-1:0] hist;
        int            uidx;
        int            cidx;
        model_predict(int'(lookup_pc), hit, taken, tgt, hist);
        @(posedge clk);
        if (update_valid) begin
            uidx = int'(update_pc) % DEPTH;
            cidx = gshare ? (uidx ^ int'(update_hist)) : uidx;
            if (update_taken) begin
                m_ctr[cidx]    = (m_ctr[cidx] < CMAX) ? m_ctr[cidx] + 1 : CMAX;
                m_valid[uidx]  = 1'b1;
                m_tag[uidx]    = int'(update_pc) / DEPTH;
                m_target[uidx] = int'(update_target);
            end else begin
                m_ctr[cidx] = (m_ctr[cidx] > 0) ? m_ctr[cidx] - 1 : 0;
            end
            if (update_mispredict && m_perf < 65535) m_perf++;
        end
        if (gshare) begin
            if (update_valid && update_mispredict)
                m_ghr = (int'(update_hist) * 2 + int'(update_taken)) % DEPTH;
            else if (lookup_valid && hit)
                m_ghr = (m_ghr * 2 + int'(taken)) % DEPTH;
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        drive(0, 16'h0010, 0, 16'h0, 0, 16'h0, 0, 4'h0);
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(0, 16'h0010, 0, 16'h0, 0, 16'h0, 0, 4'h0);
        model_reset();
        #1;
        vectors++; if (btb_hit !== 1'b0) begin miscompares++; $display("FAIL reset_hit: got %b want 0", btb_hit); end
        vectors++; if (predicted_taken !== 1'b0) begin miscompares++; $display("FAIL reset_taken: got %b want 0", predicted_taken); end
        vectors++; if (predicted_target !== 16'h0011) begin miscompares++; $display("FAIL reset_target: got %h want 0011", predicted_target); end
        vectors++; if (perf_mispredicts !== 16'h0000) begin miscompares++; $display("FAIL reset_perf: got %h want 0000", perf_mispredicts); end
        vectors++; if (predict_hist !== 4'h0) begin miscompares++; $display("FAIL reset_hist: got %h want 0", predict_hist); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Install 0x0012 then walk its counter down and back up.
    task automatic test_counter_training();
        bit step_taken [7] = '{1, 0, 0, 0, 0, 1, 1};
        bit exp_taken  [7] = '{1, 1, 0, 0, 0, 0, 1};
        for (int i = 0; i < 7; i++) begin
            drive(0, 16'h0012, 1, 16'h0012, step_taken[i], 16'h0040, 0, 4'h0);
            tick();
            drive(0, 16'h0012, 0, 16'h0, 0, 16'h0, 0, 4'h0);
            #1;
            vectors++; if (btb_hit !== 1'b1) begin miscompares++; $display("FAIL ctr_hit[%0d]: got %b want 1", i, btb_hit); end
            vectors++; if (predicted_taken !== exp_taken[i]) begin miscompares++; $display("FAIL ctr_taken[%0d]: got %b want %b", i, predicted_taken, exp_taken[i]); end
            vectors++; if (predicted_target !== (exp_taken[i] ? 16'h0040 : 16'h0013)) begin
                miscompares++; $display("FAIL ctr_target[%0d]: got %h want %h", i, predicted_target, exp_taken[i] ? 16'h0040 : 16'h0013);
            end
        end
    endtask

    task automatic test_tag_and_wrap();
        drive(0, 16'h0022, 0, 16'h0, 0, 16'h0, 0, 4'h0);
        #1;
        vectors++; if (btb_hit !== 1'b0) begin miscompares++; $display("FAIL alias_hit: got %b want 0", btb_hit); end
        vectors++; if (predicted_target !== 16'h0023) begin miscompares++; $display("FAIL alias_target: got %h want 0023", predicted_target); end
        drive(0, 16'hFFFF, 0, 16'h0, 0, 16'h0, 0, 4'h0);
        #1;
        vectors++; if (predicted_target !== 16'h0000) begin miscompares++; $display("FAIL wrap_target: got %h want 0000", predicted_target); end
        // Same-cycle update and lookup on one entry: lookup sees old state.
        drive(0, 16'h0035, 1, 16'h0035, 1, 16'h0099, 0, 4'h0);
        #1;
        vectors++; if (btb_hit !== 1'b0) begin miscompares++; $display("FAIL nobypass_hit: got %b want 0", btb_hit); end
        tick();
        drive(0, 16'h0035, 0, 16'h0, 0, 16'h0, 0, 4'h0);
        #1;
        vectors++; if (predicted_target !== 16'h0099) begin miscompares++; $display("FAIL after_update_target: got %h want 0099", predicted_target); end
    endtask

`ifdef BHT_GSHARE_EN
    task automatic test_gshare();
        logic [IB-1:0] exp_hist [3] = '{4'b0001, 4'b0011, 4'b0111};
        apply_reset();
        drive(0, 16'h0012, 1, 16'h0012, 1, 16'h0040, 0, 4'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 16'h0012, 0, 16'h0, 0, 16'h0, 0, 4'h0);
            #1;
            vectors++; if (predicted_taken !== 1'b1) begin miscompares++; $display("FAIL gs_taken[%0d]: got %b want 1", i, predicted_taken); end
            tick();
            vectors++; if (predict_hist !== exp_hist[i]) begin miscompares++; $display("FAIL gs_hist[%0d]: got %b want %b", i, predict_hist, exp_hist[i]); end
        end
        // Repair wins over a simultaneous speculative hit.
        drive(1, 16'h0012, 1, 16'h0055, 0, 16'h0, 1, 4'b0001);
        tick();
        drive(0, 16'h0012, 0, 16'h0, 0, 16'h0, 0, 4'h0);
        #1;
        vectors++; if (predict_hist !== 4'b0010) begin miscompares++; $display("FAIL gs_repair: got %b want 0010", predict_hist); end
    endtask
`endif

    task automatic test_random();
        logic [PW-1:0] pool [8] = '{16'h0012, 16'h0022, 16'h1232, 16'h00A5,
                                    16'h00B5, 16'hFFFF, 16'h000F, 16'h7FF0};
        bit            e_hit;
        bit            e_taken;
        logic [PW-1:0] e_tgt;
        logic [IB-1:0] e_hist;
        logic [PW-1:0] lpc;
        logic [PW-1:0] upc;
        int            r;
        for (int i = 0; i < 1500; i++) begin
            r   = int'($urandom_range(0, 9));
            lpc = (r < 8) ? pool[r] : PW'($urandom);
            upc = pool[$urandom_range(0, 7)];
            drive(1'($urandom), lpc, 1'($urandom), upc, 1'($urandom), PW'($urandom),
                  ($urandom_range(0, 3) == 0), IB'($urandom));
            model_predict(int'(lpc), e_hit, e_taken, e_tgt, e_hist);
            #1;
            vectors++; if (btb_hit !== e_hit) begin miscompares++; $display("FAIL rnd_hit[%0d] pc=%h: got %b want %b", i, lpc, btb_hit, e_hit); end
            vectors++; if (predicted_taken !== e_taken) begin miscompares++; $display("FAIL rnd_taken[%0d] pc=%h: got %b want %b", i, lpc, predicted_taken, e_taken); end
            vectors++; if (predicted_target !== e_tgt) begin miscompares++; $display("FAIL rnd_target[%0d] pc=%h: got %h want %h", i, lpc, predicted_target, e_tgt); end
            vectors++; if (predict_hist !== e_hist) begin miscompares++; $display("FAIL rnd_hist[%0d]: got %h want %h", i, predict_hist, e_hist); end
            vectors++; if (perf_mispredicts !== 16'(m_perf)) begin miscompares++; $display("FAIL rnd_perf[%0d]: got %0d want %0d", i, perf_mispredicts, m_perf); end
            tick();
        end
    endtask

    task automatic test_perf_saturation_and_async_reset();
        for (int i = 0; i < 65540; i++) begin
            drive(0, 16'h0012, 1, 16'h0012, 1, 16'h0040, 1, 4'h0);
            tick();
            if (i == 100) begin
                vectors++; if (perf_mispredicts !== 16'(m_perf)) begin miscompares++; $display("FAIL perf_mid: got %0d want %0d", perf_mispredicts, m_perf); end
            end
        end
        vectors++; if (perf_mispredicts !== 16'hFFFF) begin miscompares++; $display("FAIL perf_sat: got %h want FFFF", perf_mispredicts); end
        vectors++; if (btb_hit !== 1'b1) begin miscompares++; $display("FAIL pre_reset_hit: got %b want 1", btb_hit); end
        // Reset between edges must act immediately.
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        vectors++; if (perf_mispredicts !== 16'h0000) begin miscompares++; $display("FAIL async_perf: got %h want 0000", perf_mispredicts); end
        vectors++; if (btb_hit !== 1'b0) begin miscompares++; $display("FAIL async_hit: got %b want 0", btb_hit); end
        vectors++; if (predicted_target !== 16'h0013) begin miscompares++; $display("FAIL async_target: got %h want 0013", predicted_target); end
        // An update presented while reset is held is dropped.
        @(negedge clk);
        reset_n = 1'b1;
        drive(0, 16'h0012, 0, 16'h0, 0, 16'h0, 0, 4'h0);
        #1;
        vectors++; if (btb_hit !== 1'b0) begin miscompares++; $display("FAIL dropped_hit: got %b want 0", btb_hit); end
        vectors++; if (perf_mispredicts !== 16'h0000) begin miscompares++; $display("FAIL dropped_perf: got %h want 0000", perf_mispredicts); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef BHT_GSHARE_EN
        gshare = 1'b1;
`else
        gshare = 1'b0;
`endif
        test_reset();
        test_counter_training();
        test_tag_and_wrap();
`ifdef BHT_GSHARE_EN
        test_gshare();
`endif
        test_random();
        test_perf_saturation_and_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/branch_history_table.md
# branch_history_table

Parametrised direct-mapped branch predictor combining a table of saturating counters with a tagged branch target buffer (BTB). It replaces the single global 2-bit counter in the fetch stage of the multi-cycle CPU.
- Fetch presents the PC and receives a taken/not-taken prediction plus a next-PC target in the same cycle.
- Execute later reports the resolved outcome, which trains the counters and the BTB.
- A saturating mispredict counter is kept for performance measurement.

## Interface
- PC_WIDTH, 16, width of PC and target fields
- INDEX_BITS, 4, log2 of table depth (counter table and BTB both have 2^INDEX_BITS entries)
- CTR_BITS, 2, saturating counter width (≥2)
- clk  in  1  clock; all state updates on posedge
- reset_n  in  1  asynchronous, active-low reset
- lookup_valid  in  1  fetch is requesting a prediction this cycle
- lookup_pc  in  PC_WIDTH  PC of the instruction being fetched
- btb_hit  out  1  BTB entry valid and tag matches lookup_pc
- predicted_taken  out  1  btb_hit AND counter MSB = 1
- predicted_target  out  PC_WIDTH  BTB target if predicted_taken, else lookup_pc + 1
- predict_hist  out  INDEX_BITS  history snapshot used for this lookup (0 when gshare is compiled out)
- update_valid  in  1  resolved branch report
- update_pc  in  PC_WIDTH  PC of the resolved branch
- update_taken  in  1  actual direction
- update_target  in  PC_WIDTH  actual taken target
- update_mispredict  in  1  the earlier prediction was wrong
- update_hist  in  INDEX_BITS  predict_hist captured at lookup time for this branch
- perf_mispredicts  out  16  saturating count of mispredicts

## Operation
- BTB index = pc[INDEX_BITS-1:0]; tag = pc[PC_WIDTH-1:INDEX_BITS]. Each entry holds valid, tag, target.
- Counter index = pc[INDEX_BITS-1:0]; with gshare enabled, it is XORed with the history (see Configuration).
- Lookup is purely combinational from lookup_pc, table state and history. lookup_valid gates only history speculation.
- Counter update on update_valid:
  - taken: ctr + 1, saturating at 2^CTR_BITS-1.
  - not taken: ctr - 1, saturating at 0.
- BTB write on update_valid & update_taken: valid = 1, tag and target written. Not-taken updates leave the BTB unchanged.
- perf_mispredicts increments on update_valid & update_mispredict and holds at 0xFFFF.
- Reset state:
  - all counters = all-ones (strongly taken);
  - all BTB valid bits = 0;
  - history = 0;
  - perf_mispredicts = 0.
- Post-reset outputs: btb_hit = 0, predicted_taken = 0, predicted_target = lookup_pc + 1, predict_hist = 0.
- PC + 1 wraps modulo 2^PC_WIDTH (0xFFFF → 0x0000).

## Timing
- Lookup latency is 0 cycles (combinational). Update takes effect at the next posedge and is visible to a lookup in the following cycle.
- Same-cycle lookup and update to the same entry: the lookup sees pre-update state. No bypass.
- Reset assertion mid-operation clears state immediately, independent of clk. Any update in flight that cycle is dropped.
- No handshake and no back-pressure: every update_valid is consumed in its cycle.

## Configuration
- BHT_GSHARE_EN defined: an INDEX_BITS global history register (GHR) is built.
  - Counter index = pc[INDEX_BITS-1:0] ^ GHR for lookup; update_pc[INDEX_BITS-1:0] ^ update_hist for update.
  - predict_hist = GHR.
  - On lookup_valid & btb_hit: GHR ← {GHR[INDEX_BITS-2:0], predicted_taken}.
  - On update_valid & update_mispredict: GHR ← {update_hist[INDEX_BITS-2:0], update_taken}. Repair has priority over speculation in the same cycle.
- BHT_GSHARE_EN undefined: no GHR is built.
  - Counter index = pc low bits only.
  - predict_hist = 0 and update_hist is ignored.

## Test plan
- Reset, lookup_pc = 0x0010 → btb_hit = 0, predicted_taken = 0, predicted_target = 0x0011, perf_mispredicts = 0.
- Update pc 0x0012, taken, target 0x0040; next cycle lookup 0x0012 → btb_hit = 1, predicted_taken = 1, target = 0x0040; counter stays 2'b11 (saturated).
- Two not-taken updates on 0x0012 → after first: still taken (2'b10); after second: predicted_taken = 0, target 0x0013 (2'b01). A third and fourth update → counter floors at 2'b00; one taken update → 2'b01, still not taken.
- After entry 0x0012 is installed, lookup 0x0022 (same index, different tag) → btb_hit = 0, target 0x0023.
- 65540 updates with update_mispredict = 1 → perf_mispredicts = 0xFFFF; then pull reset_n low between clock edges → counter 0 and btb_hit 0 immediately.
- With BHT_GSHARE_EN: three hit lookups predicted taken → predict_hist = 4'b0111; a mispredict update with update_hist = 4'b0001, not taken → GHR = 4'b0010 next cycle.
